// File: rtl/window_gen_kxk.sv
// K x K sliding-window generator: K-1 line buffers, a K x K tap array and a
// fixed 2-cycle output latency. Optional WINDOW_POS_OUT_EN adds win_row/win_col.
module window_gen_kxk #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 508,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            frame_start,
    input  logic                                            pix_valid,
    input  logic [DATA_WIDTH-1:0]                           pix_data,
    output logic                                            busy,
    output logic                                            win_valid,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   win_data,
    output logic                                            win_sof,
    output logic                                            win_eol,
    output logic                                            win_eof
`ifdef WINDOW_POS_OUT_EN
    ,
    output logic [$clog2(IMG_HEIGHT)-1:0]                   win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]                    win_col
`endif
);

    // state  | meaning
    // S_IDLE | waiting for a valid pixel with frame_start
    // S_RUN  | frame in progress, every valid pixel is accepted
    localparam int K    = KERNEL_SIZE;
    localparam int NB   = K - 1;
    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int HALF = (K - 1) / 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_col, w_col_nxt, w_col_cur;
    logic [RW-1:0]   r_row, w_row_nxt, w_row_cur;
    logic            w_accept;
    logic            w_emit;

    logic [DATA_WIDTH-1:0] r_lb [NB][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] w_lb_rd [NB];

    logic                  r_s1_shift, r_s1_emit, r_s1_sof, r_s1_eol, r_s1_eof;
    logic [DATA_WIDTH-1:0] r_s1_col [K];
    logic [DATA_WIDTH-1:0] r_win [K][K];
    logic                  r_s2_emit, r_s2_sof, r_s2_eol, r_s2_eof;
    logic [K*K*DATA_WIDTH-1:0] w_win_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_row_cur   = r_row;
        w_col_cur   = r_col;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            S_IDLE: begin
                if (pix_valid && frame_start) begin
                    w_accept    = 1'b1;
                    w_row_cur   = '0;
                    w_col_cur   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (pix_valid) begin
                    w_accept = 1'b1;
                    if (frame_start) begin
                        w_row_cur = '0;
                        w_col_cur = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_accept) begin
            if (w_col_cur == COL_LAST) begin
                w_col_nxt = '0;
                w_row_nxt = w_row_cur + RW'(1);
            end else begin
                w_col_nxt = w_col_cur + CW'(1);
                w_row_nxt = w_row_cur;
            end
            if (w_col_cur == COL_LAST && w_row_cur == ROW_LAST) begin
                w_state_nxt = S_IDLE;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign w_emit = w_accept && (w_row_cur >= ROW_MIN) && (w_col_cur >= COL_MIN);

    // Asynchronous read gives read-before-write on the column being written.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_lb_rd[i] = r_lb[i][w_col_cur];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][w_col_cur] <= pix_data;
            for (int i = 1; i < NB; i++) begin
                r_lb[i][w_col_cur] <= w_lb_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_shift <= 1'b0;
            r_s1_emit  <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_eof   <= 1'b0;
            for (int r = 0; r < K; r++) begin
                r_s1_col[r] <= '0;
            end
        end else begin
            r_s1_shift <= w_accept;
            r_s1_emit  <= w_emit;
            if (w_accept) begin
                r_s1_sof <= (w_row_cur == ROW_MIN) && (w_col_cur == COL_MIN);
                r_s1_eol <= (w_col_cur == COL_LAST);
                r_s1_eof <= (w_row_cur == ROW_LAST) && (w_col_cur == COL_LAST);
                r_s1_col[K-1] <= pix_data;
                for (int r = 0; r < K - 1; r++) begin
                    r_s1_col[r] <= w_lb_rd[K-2-r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_s2_emit <= 1'b0;
            r_s2_sof  <= 1'b0;
            r_s2_eol  <= 1'b0;
            r_s2_eof  <= 1'b0;
        end else begin
            if (r_s1_shift) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                    r_win[r][K-1] <= r_s1_col[r];
                end
            end
            r_s2_emit <= r_s1_shift && r_s1_emit;
            r_s2_sof  <= r_s1_sof;
            r_s2_eol  <= r_s1_eol;
            r_s2_eof  <= r_s1_eof;
        end
    end

    always_comb begin
        w_win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_win_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
            end
        end
    end

    // Data and flags only load with a window, so they hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_sof   <= 1'b0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
        end else begin
            win_valid <= r_s2_emit;
            if (r_s2_emit) begin
                win_data <= w_win_flat;
                win_sof  <= r_s2_sof;
                win_eol  <= r_s2_eol;
                win_eof  <= r_s2_eof;
            end
        end
    end

`ifdef WINDOW_POS_OUT_EN
    logic [RW-1:0] r_s1_prow, r_s2_prow;
    logic [CW-1:0] r_s1_pcol, r_s2_pcol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_prow <= '0;
            r_s1_pcol <= '0;
            r_s2_prow <= '0;
            r_s2_pcol <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_prow <= w_row_cur - RW'(HALF);
                r_s1_pcol <= w_col_cur - CW'(HALF);
            end
            if (r_s1_shift) begin
                r_s2_prow <= r_s1_prow;
                r_s2_pcol <= r_s1_pcol;
            end
            if (r_s2_emit) begin
                win_row <= r_s2_prow;
                win_col <= r_s2_pcol;
            end
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_kxk.sv
// Bench for window_gen_kxk: a K=3 8x6 instance and a K=5 10x7 instance, each
// compared cycle by cycle against a frame-image reference model.
module tb_window_gen_kxk;

    localparam int DW = 16;
    localparam int KA = 3, WA = 8,  HA = 6;
    localparam int KB = 5, WB = 10, HB = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic fs_a = 1'b0, pv_a = 1'b0, fs_b = 1'b0, pv_b = 1'b0;
    logic [DW-1:0] pd_a = '0, pd_b = '0;
    logic busy_a, wv_a, sof_a, eol_a, eof_a;
    logic busy_b, wv_b, sof_b, eol_b, eof_b;
    logic [KA*KA*DW-1:0] wd_a;
    logic [KB*KB*DW-1:0] wd_b;
`ifdef WINDOW_POS_OUT_EN
    logic [$clog2(HA)-1:0] wr_a;
    logic [$clog2(WA)-1:0] wc_a;
    logic [$clog2(HB)-1:0] wr_b;
    logic [$clog2(WB)-1:0] wc_b;
`endif

    window_gen_kxk #(.IMG_WIDTH(WA), .IMG_HEIGHT(HA), .KERNEL_SIZE(KA), .DATA_WIDTH(DW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .pix_valid(pv_a), .pix_data(pd_a),
        .busy(busy_a), .win_valid(wv_a), .win_data(wd_a),
        .win_sof(sof_a), .win_eol(eol_a), .win_eof(eof_a)
`ifdef WINDOW_POS_OUT_EN
        , .win_row(wr_a), .win_col(wc_a)
`endif
    );

    window_gen_kxk #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB), .KERNEL_SIZE(KB), .DATA_WIDTH(DW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .pix_valid(pv_b), .pix_data(pd_b),
        .busy(busy_b), .win_valid(wv_b), .win_data(wd_b),
        .win_sof(sof_b), .win_eol(eol_b), .win_eof(eof_b)
`ifdef WINDOW_POS_OUT_EN
        , .win_row(wr_b), .win_col(wc_b)
`endif
    );

    typedef struct {
        logic [399:0] data;
        bit sof, eol, eof;
        int due, prow, pcol;
    } exp_t;

    exp_t qa[$], qb[$];
    logic [DW-1:0] img [2][10][10];
    bit   in_frame [2];
    int   mrow [2], mcol [2];
    int   wcount [2], sofcount [2], eolcount [2], eofcount [2];
    logic [399:0] last_data [2];
    logic [2:0]   last_flags [2];
    logic [399:0] first_a;
    logic [DW-1:0] eof_tap_a;
    int cyc = 0;
    int n_checks = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int kk(int id); return (id == 0) ? KA : KB; endfunction
    function automatic int ww(int id); return (id == 0) ? WA : WB; endfunction
    function automatic int hh(int id); return (id == 0) ? HA : HB; endfunction

    task automatic chk(string tag, logic [399:0] obs, logic [399:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level model: place the pixel in the frame image and, if its
    // neighbourhood is complete, queue the window due 2 edges later.
    task automatic model_accept(int id, bit fs, bit v, logic [DW-1:0] d, int edge_n);
        int r, c, k, w, h;
        exp_t e;
        if (!(v && (fs || in_frame[id]))) return;
        k = kk(id); w = ww(id); h = hh(id);
        r = fs ? 0 : mrow[id];
        c = fs ? 0 : mcol[id];
        img[id][r][c] = d;
        if (r >= k - 1 && c >= k - 1) begin
            e.data = '0;
            for (int rr = 0; rr < k; rr++)
                for (int cc = 0; cc < k; cc++)
                    e.data[(rr*k+cc)*DW +: DW] = img[id][r-k+1+rr][c-k+1+cc];
            e.sof  = (r == k - 1) && (c == k - 1);
            e.eol  = (c == w - 1);
            e.eof  = (r == h - 1) && (c == w - 1);
            e.due  = edge_n + 3;
            e.prow = r - (k - 1) / 2;
            e.pcol = c - (k - 1) / 2;
            if (id == 0) qa.push_back(e); else qb.push_back(e);
        end
        if (r == h - 1 && c == w - 1) begin
            in_frame[id] = 1'b0;
            mrow[id] = 0;
            mcol[id] = 0;
        end else begin
            in_frame[id] = 1'b1;
            mcol[id] = (c == w - 1) ? 0 : c + 1;
            mrow[id] = (c == w - 1) ? r + 1 : r;
        end
    endtask

    task automatic step(int id, bit fs, bit v, logic [DW-1:0] d);
        int e;
        if (id == 0) begin fs_a = fs; pv_a = v; pd_a = d; end
        else         begin fs_b = fs; pv_b = v; pd_b = d; end
        @(posedge clk);
        e = cyc;
        model_accept(id, fs, v, d, e);
        #1;
        fs_a = 1'b0; pv_a = 1'b0; fs_b = 1'b0; pv_b = 1'b0;
        chk(id == 0 ? "busy_a" : "busy_b", id == 0 ? busy_a : busy_b, in_frame[id]);
    endtask

    task automatic check_out(int id, bit v, logic [399:0] d, bit sof, bit eol, bit eof,
                             int prow, int pcol);
        exp_t h;
        bit ev;
        ev = 1'b0;
        if (id == 0 && qa.size() > 0) ev = (qa[0].due == cyc);
        if (id == 1 && qb.size() > 0) ev = (qb[0].due == cyc);
        chk(id == 0 ? "win_valid_a" : "win_valid_b", v, ev);
        if (ev) begin
            h = (id == 0) ? qa.pop_front() : qb.pop_front();
            chk("win_data", d, h.data);
            chk("win_flags", {sof, eol, eof}, {h.sof, h.eol, h.eof});
`ifdef WINDOW_POS_OUT_EN
            chk("win_row", prow, h.prow);
            chk("win_col", pcol, h.pcol);
`endif
            wcount[id]++;
            if (sof) sofcount[id]++;
            if (eol) eolcount[id]++;
            if (eof) eofcount[id]++;
            if (id == 0 && sof) first_a = d;
            if (id == 0 && eof) eof_tap_a = d[8*DW +: DW];
            last_data[id]  = d;
            last_flags[id] = {sof, eol, eof};
        end else if (!v) begin
            chk("win_hold", {d, sof, eol, eof}, {last_data[id], last_flags[id]});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
`ifdef WINDOW_POS_OUT_EN
            check_out(0, wv_a, {256'b0, wd_a}, sof_a, eol_a, eof_a, int'(wr_a), int'(wc_a));
            check_out(1, wv_b, wd_b, sof_b, eol_b, eof_b, int'(wr_b), int'(wc_b));
`else
            check_out(0, wv_a, {256'b0, wd_a}, sof_a, eol_a, eof_a, 0, 0);
            check_out(1, wv_b, wd_b, sof_b, eol_b, eof_b, 0, 0);
`endif
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            wcount[i] = 0; sofcount[i] = 0; eolcount[i] = 0; eofcount[i] = 0;
        end
    endtask

    task automatic clear_model();
        qa.delete(); qb.delete();
        for (int i = 0; i < 2; i++) begin
            in_frame[i] = 1'b0; mrow[i] = 0; mcol[i] = 0;
            last_data[i] = '0; last_flags[i] = '0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_valid_a", wv_a, 1'b0);
        chk("rst_data_a", {256'b0, wd_a}, '0);
        chk("rst_flags_a", {sof_a, eol_a, eof_a}, 3'b000);
        chk("rst_busy_b", busy_b, 1'b0);
        chk("rst_valid_b", wv_b, 1'b0);
        chk("rst_data_b", wd_b, '0);
        chk("rst_flags_b", {sof_b, eol_b, eof_b}, 3'b000);
    endtask

    task automatic send_frame_a(logic [DW-1:0] base, bit bubbles);
        for (int r = 0; r < HA; r++)
            for (int c = 0; c < WA; c++) begin
                if (bubbles) begin
                    int nb;
                    nb = $urandom_range(0, 2);
                    for (int b = 0; b < nb; b++) step(0, 1'($urandom_range(0, 1)), 1'b0, '0);
                end
                step(0, (r == 0 && c == 0), 1'b1, base + DW'(r * 16 + c));
            end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [399:0] exp_first;
        clear_model();
        clear_counts();
        first_a = '0;
        eof_tap_a = '0;
        #3;
        check_reset_outputs();
        #20;
        rst_n = 1'b1;
        idle(2);

        // Pixels before any frame_start are dropped
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, DW'($urandom));
        idle(3);
        chk("pre_fs_windows", wcount[0], 0);

        // Continuous frame with pix_data = row*16+col
        send_frame_a(16'h0000, 1'b0);
        idle(4);
        chk("f1_windows", wcount[0], 24);
        chk("f1_sof", sofcount[0], 1);
        chk("f1_eol", eolcount[0], 4);
        chk("f1_eof", eofcount[0], 1);
        exp_first = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_first[(r*3+c)*DW +: DW] = DW'(r * 16 + c);
        chk("f1_first_window", first_a, exp_first);
        chk("f1_eof_tap22", eof_tap_a, 16'h0057);

        // Same frame with random bubbles and stray frame_start without valid
        clear_counts();
        send_frame_a(16'h0000, 1'b1);
        idle(4);
        chk("f2_windows", wcount[0], 24);
        chk("f2_first_window", first_a, exp_first);

        // Pixels after frame end without frame_start are dropped
        clear_counts();
        for (int i = 0; i < 10; i++) step(0, 1'b0, 1'b1, DW'($urandom));
        idle(3);
        chk("post_frame_windows", wcount[0], 0);

        // Abort at pixel (3,4): old-frame windows drain, then a clean new frame
        clear_counts();
        for (int i = 0; i < 28; i++)
            step(0, (i == 0), 1'b1, 16'h0200 + DW'((i / WA) * 16 + (i % WA)));
        send_frame_a(16'h0300, 1'b0);
        idle(4);
        chk("abort_windows", wcount[0], 8 + 24);
        chk("abort_sof", sofcount[0], 2);
        chk("abort_eof", eofcount[0], 1);

        // K=5 instance, random pixel data
        clear_counts();
        for (int r = 0; r < HB; r++)
            for (int c = 0; c < WB; c++) begin
                if ($urandom_range(0, 3) == 0) step(1, 1'b0, 1'b0, '0);
                step(1, (r == 0 && c == 0), 1'b1, DW'($urandom));
            end
        idle(4);
        chk("k5_windows", wcount[1], 18);
        chk("k5_sof", sofcount[1], 1);
        chk("k5_eof", eofcount[1], 1);

        // Asynchronous reset mid-frame with windows in flight
        clear_counts();
        for (int i = 0; i < 20; i++) step(0, (i == 0), 1'b1, DW'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_reset_outputs();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, DW'($urandom));
        idle(3);
        chk("post_reset_windows", wcount[0], 0);
        send_frame_a(16'h0400, 1'b1);
        idle(4);
        chk("recover_windows", wcount[0], 24);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
